// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if : instruction-memory and decoder-side signals of fetch_ctrl.
//   addr_instr  fetch address to instr_mem (mirrors pc)
//   mem_en      fetch enable to instr_mem
//   opcode_in   combinational opcode returned by instr_mem
//   instr       registered instruction to the decoder
//   instr_valid instr holds an unconsumed instruction
//   instr_ready decoder accepts instr this cycle
//   jump_valid  single-cycle redirect request from execute
//   jump_addr   redirect target
// master = fetch_ctrl side, slave = memory/decoder/execute side.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned OPCODE_WIDTH = 8
);
    logic [BUS_WIDTH-1:0]    addr_instr;
    logic                    mem_en;
    logic [OPCODE_WIDTH-1:0] opcode_in;
    logic [OPCODE_WIDTH-1:0] instr;
    logic                    instr_valid;
    logic                    instr_ready;
    logic                    jump_valid;
    logic [BUS_WIDTH-1:0]    jump_addr;

    modport master (
        output addr_instr, mem_en, instr, instr_valid,
        input  opcode_in, instr_ready, jump_valid, jump_addr
    );

    modport slave (
        input  addr_instr, mem_en, instr, instr_valid,
        output opcode_in, instr_ready, jump_valid, jump_addr
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl : instruction fetch sequencer.
// Owns the PC, drives instr_mem address/enable, captures the returned opcode
// into an instruction register and offers it to the decoder over valid/ready.
// Redirects from execute flush the held instruction and reload the PC.
//
// Ports:
//   clk       system clock, rising edge
//   nrst      asynchronous active-low reset
//   run       level, enables fetching
//   pc        address of the next fetch
//   halted    stopped on a halt instruction (0 unless FETCH_HALT_EN)
//   bus       fetch_ctrl_if.master (memory, decoder and redirect signals)
//
// Build option:
//   FETCH_HALT_EN  when defined, a transferred HALT_OPCODE stops the unit
//                  until reset; otherwise HALT_OPCODE is an ordinary opcode.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int unsigned                 BUS_WIDTH    = 8,
    parameter int unsigned                 OPCODE_WIDTH = 8,
    parameter logic [BUS_WIDTH-1:0]        RESET_PC     = '0,
    parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE  = OPCODE_WIDTH'(8'hFF)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 run,
    output logic [BUS_WIDTH-1:0] pc,
    output logic                 halted,
    fetch_ctrl_if.master         bus
);

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [BUS_WIDTH-1:0]    pc_q, pc_d;
    logic [OPCODE_WIDTH-1:0] instr_q, instr_d;
    logic                    mem_en_c;
    logic                    transfer_c;
    logic                    halt_hold_c;

    // A held halt opcode blocks further fetching until it is consumed.
    assign transfer_c  = (state_q == VALID) && bus.instr_ready;
    assign halt_hold_c = HaltEn && (state_q == VALID) && (instr_q == HALT_OPCODE);

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state, datapath update and memory enable.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        mem_en_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.jump_valid) begin
                    pc_d = bus.jump_addr;
                end else if (run) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                mem_en_c = 1'b1;
                if (bus.jump_valid) begin
                    pc_d    = bus.jump_addr;
                    state_d = run ? FETCH : IDLE;
                end else if (!run) begin
                    state_d = IDLE;
                end else begin
                    instr_d = bus.opcode_in;
                    pc_d    = pc_q + BUS_WIDTH'(1);
                    state_d = VALID;
                end
            end

            VALID: begin
                mem_en_c = bus.instr_ready && run && !halt_hold_c;
                // A redirect wins over capture; a concurrent transfer is still consumed.
                if (bus.jump_valid) begin
                    pc_d    = bus.jump_addr;
                    state_d = run ? FETCH : IDLE;
                end else if (transfer_c) begin
                    if (halt_hold_c) begin
                        state_d = HALT;
                    end else if (run) begin
                        instr_d = bus.opcode_in;
                        pc_d    = pc_q + BUS_WIDTH'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            HALT: begin
                // Terminal until reset; redirects are ignored.
            end
        endcase
    end

    assign bus.addr_instr  = pc_q;
    assign bus.mem_en      = mem_en_c;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == VALID);
    assign pc              = pc_q;

`ifdef FETCH_HALT_EN
    assign halted = (state_q == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl : table-driven bench for fetch_ctrl with an instr_mem model.
// Each vector drives inputs after the falling edge and checks the outputs
// of that cycle before the next rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic       clk;
    logic       nrst;
    logic       run;
    logic [7:0] pc;
    logic       halted;
    logic [7:0] mem [256];

    int errors = 0;
    int checks = 0;

    fetch_ctrl_if #(.BUS_WIDTH(8), .OPCODE_WIDTH(8)) bus ();

    fetch_ctrl #(
        .BUS_WIDTH    (8),
        .OPCODE_WIDTH (8),
        .RESET_PC     (8'h00),
        .HALT_OPCODE  (8'hFF)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .run    (run),
        .pc     (pc),
        .halted (halted),
        .bus    (bus)
    );

    assign bus.opcode_in = mem[bus.addr_instr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       rdy;
        logic       jv;
        logic [7:0] ja;
        logic [7:0] e_pc;
        logic [7:0] e_instr;
        logic       e_valid;
        logic       e_men;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic jv, input logic [7:0] ja);
        @(negedge clk);
        run             = r;
        bus.instr_ready = rdy;
        bus.jump_valid  = jv;
        bus.jump_addr   = ja;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_pc, input logic [7:0] e_instr,
                              input logic e_valid, input logic e_men);
        check({tag, ".pc"},          32'(pc),              32'(e_pc));
        check({tag, ".addr_instr"},  32'(bus.addr_instr),  32'(e_pc));
        check({tag, ".instr"},       32'(bus.instr),       32'(e_instr));
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(e_valid));
        check({tag, ".mem_en"},      32'(bus.mem_en),      32'(e_men));
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'h44;
        mem[4] = 8'h55;

        nrst            = 1'b0;
        run             = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jump_valid  = 1'b0;
        bus.jump_addr   = 8'h00;

        // Reset state.
        #3;
        check_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset.halted", 32'(halted), 32'(0));
        @(negedge clk);
        nrst = 1'b1;

        //             run   rdy   jv    ja     pc     instr  valid mem_en
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0}); // idle, run rises
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1}); // fetch
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 8'h11, 1'b1, 1'b1}); // first valid
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h22, 1'b1, 1'b0}); // backpressure x3
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h22, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h22, 1'b1, 1'b0});
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 8'h22, 1'b1, 1'b1}); // release
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h03, 8'h33, 1'b1, 1'b1});
        vq.push_back('{1'b1, 1'b1, 1'b1, 8'h40, 8'h04, 8'h44, 1'b1, 1'b1}); // jump during transfer
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 8'h44, 1'b0, 1'b1}); // flushed, fetch @40
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h41, 8'hE5, 1'b1, 1'b0}); // mem[40]
        vq.push_back('{1'b1, 1'b0, 1'b1, 8'hFF, 8'h41, 8'hE5, 1'b1, 1'b0}); // jump w/o transfer
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hE5, 1'b0, 1'b1}); // fetch @FF
        vq.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b1, 1'b1}); // mem[FF], pc wrapped
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h11, 1'b1, 1'b0}); // mem[00]
        vq.push_back('{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h11, 1'b1, 1'b0}); // transfer, run low
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h11, 1'b0, 1'b0}); // idle
        vq.push_back('{1'b0, 1'b0, 1'b1, 8'h10, 8'h01, 8'h11, 1'b0, 1'b0}); // jump in idle
        vq.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 8'h11, 1'b0, 1'b0}); // pc loaded, run
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h11, 1'b0, 1'b1}); // fetch, run drops
        vq.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h11, 1'b0, 1'b0}); // back to idle

        foreach (vq[i]) begin
            drive(vq[i].run, vq[i].rdy, vq[i].jv, vq[i].ja);
            check_outs($sformatf("vec%0d", i), vq[i].e_pc, vq[i].e_instr, vq[i].e_valid, vq[i].e_men);
        end

        // Reset mid-handshake: fetch mem[10] then drop nrst between edges.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check_outs("pre_rst", 8'h11, 8'hB5, 1'b1, 1'b0);
        #1;
        nrst = 1'b0;
        #1;
        check_outs("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
        check("mid_rst.halted", 32'(halted), 32'(0));
        run = 1'b0;
        @(negedge clk);
        nrst = 1'b1;

        // Halt opcode at address 2.
        mem[2] = 8'hFF;
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // idle
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // fetch
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // 11
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // 22
        drive(1'b1, 1'b0, 1'b0, 8'h00);                // FF held
        check_outs("halt_hold", 8'h03, 8'hFF, 1'b1, 1'b0);
`ifdef FETCH_HALT_EN
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // FF transfers
        check_outs("halt_xfer", 8'h03, 8'hFF, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h40);                // halted, jump ignored
        check_outs("halted", 8'h03, 8'hFF, 1'b0, 1'b0);
        check("halted.flag", 32'(halted), 32'(1));
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check_outs("halt_stays", 8'h03, 8'hFF, 1'b0, 1'b0);
        check("halt_stays.flag", 32'(halted), 32'(1));
`else
        drive(1'b1, 1'b1, 1'b0, 8'h00);                // FF is ordinary
        check_outs("ff_xfer", 8'h03, 8'hFF, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'h00);
        check_outs("after_ff", 8'h04, 8'h44, 1'b1, 1'b1);
        check("after_ff.halted", 32'(halted), 32'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
